// File: rtl/arb_pkg.sv
// arb_pkg: shared types, default widths and the round-robin pick for ram_port_arbiter.
`timescale 1ns/1ps
package arb_pkg;

    localparam int ARB_ADDR_W = 12;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

    typedef enum logic {OWN_CPU = 1'b0, OWN_FPGA = 1'b1} owner_t;

    // A lone requester wins. On a tie the requester not granted last wins,
    // except that a locked host keeps ownership it already holds.
    function automatic owner_t rr_pick(input logic cpu_req, input logic fpga_req,
                                       input logic fpga_lock, input owner_t last_grant);
        owner_t win;
        if (!fpga_req)
            win = OWN_CPU;
        else if (!cpu_req)
            win = OWN_FPGA;
        else if (last_grant == OWN_CPU || fpga_lock)
            win = OWN_FPGA;
        else
            win = OWN_CPU;
        return win;
    endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single ram data port between the CPU and the FPGA host.
// Ports:
//   clk, nrst                               clock, async active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack/rdata  CPU load/store request and completion
//   fpga_req/we/addr/wdata, fpga_lock       host request, lock keeps host ownership
//   fpga_ack/rdata                          host completion
//   ram_addr/we/wdata, ram_rdata            ram data port (1-cycle registered read)
//   cpu_enable                              0 stalls the pc while the host owns memory
//   owner                                   current/last grant, 0 = CPU, 1 = FPGA
`timescale 1ns/1ps
module ram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              fpga_req,
    input  logic              fpga_we,
    input  logic [ADDR_W-1:0] fpga_addr,
    input  logic [DATA_W-1:0] fpga_wdata,
    input  logic              fpga_lock,
    output logic              fpga_ack,
    output logic [DATA_W-1:0] fpga_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_enable,
    output logic              owner
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, last_grant, win;
    logic              grant;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_rdata_q, fpga_rdata_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = rr_pick(cpu_req, fpga_req, fpga_lock, last_grant);
        case (state_q)
            IDLE: begin
                grant   = cpu_req || fpga_req;
                state_d = grant ? ACCESS : IDLE;
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves last_grant at FPGA so the CPU wins the first tie.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            owner_q      <= OWN_CPU;
            last_grant   <= OWN_FPGA;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            cpu_rdata_q  <= '0;
            fpga_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q    <= win;
                last_grant <= win;
                lat_we     <= (win == OWN_FPGA) ? fpga_we : cpu_we;
                lat_addr   <= (win == OWN_FPGA) ? fpga_addr : cpu_addr;
                lat_wdata  <= (win == OWN_FPGA) ? fpga_wdata : cpu_wdata;
            end
            if (cpu_ack)
                cpu_rdata_q <= ram_rdata;
            if (fpga_ack)
                fpga_rdata_q <= ram_rdata;
        end
    end

    assign cpu_ack  = (state_q == DONE) && (owner_q == OWN_CPU);
    assign fpga_ack = (state_q == DONE) && (owner_q == OWN_FPGA);

    // The ram answers during DONE, so the live read data is forwarded with the
    // ack and the captured copy is held afterwards.
    assign cpu_rdata  = cpu_ack ? ram_rdata : cpu_rdata_q;
    assign fpga_rdata = fpga_ack ? ram_rdata : fpga_rdata_q;

    assign ram_we    = (state_q == ACCESS) && lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;

    assign cpu_enable = !(fpga_lock || (owner_q == OWN_FPGA && state_q != IDLE));
    assign owner      = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a behavioural ram.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    logic        clk, nrst;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        fpga_req, fpga_we, fpga_lock, fpga_ack;
    logic [11:0] fpga_addr;
    logic [31:0] fpga_wdata, fpga_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic        cpu_enable, owner;

    ram_port_arbiter dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .fpga_req(fpga_req), .fpga_we(fpga_we), .fpga_addr(fpga_addr), .fpga_wdata(fpga_wdata),
        .fpga_lock(fpga_lock), .fpga_ack(fpga_ack), .fpga_rdata(fpga_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cpu_enable(cpu_enable), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct packed {
        logic        who;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [logic [11:0]];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_ack = -100;
    logic        prev_we = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_we <= ram_we;
        if (ram_we) begin
            n_vec++;
            if (prev_we) begin
                n_err++;
                $display("FAIL we_twice: ram_we=%0b after %0b, required not high two cycles", ram_we, prev_we);
            end
        end
        if (cpu_ack || fpga_ack) begin
            n_vec++;
            if (cpu_ack && fpga_ack) begin
                n_err++;
                $display("FAIL both_acks: cpu_ack=%0b fpga_ack=%0b, required one at a time", cpu_ack, fpga_ack);
            end
            if (cyc - last_ack < 3) begin
                n_err++;
                $display("FAIL ack_gap: %0d cycles, required >= 3", cyc - last_ack);
            end
            last_ack <= cyc;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: ack cpu=%0b fpga=%0b, required no ack", cpu_ack, fpga_ack);
            end else begin
                e = sb.pop_front();
                if (fpga_ack !== e.who) begin
                    n_err++;
                    $display("FAIL sb_who: fpga_ack=%0b, required owner %0b", fpga_ack, e.who);
                end else if (e.chk && (e.who ? fpga_rdata : cpu_rdata) !== e.data) begin
                    n_err++;
                    $display("FAIL sb_rdata: got %h, required %h", e.who ? fpga_rdata : cpu_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish");
        $fatal(1);
    end

    task automatic push(input logic who, input logic we, input logic [11:0] a, input logic [31:0] d);
        if (we)
            shadow[a] = d;
        sb.push_back({who, !we, we ? 32'h0 : shadow[a]});
    endtask

    task automatic xfer(input logic who, input logic we, input logic [11:0] a, input logic [31:0] d);
        logic ack;
        push(who, we, a, d);
        if (who) begin
            fpga_req = 1'b1; fpga_we = we; fpga_addr = a; fpga_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
        @(posedge clk); #1;
        n_vec++;
        if (ram_we !== we || ram_addr !== a || owner !== who || (we && ram_wdata !== d)) begin
            n_err++;
            $display("FAIL xfer_access: we=%0b addr=%h wdata=%h owner=%0b, required we=%0b addr=%h wdata=%h owner=%0b",
                     ram_we, ram_addr, ram_wdata, owner, we, a, d, who);
        end
        n_vec++;
        if (cpu_enable !== !who) begin
            n_err++;
            $display("FAIL xfer_enable: cpu_enable=%0b, required %0b", cpu_enable, !who);
        end
        @(posedge clk); #1;
        ack = who ? fpga_ack : cpu_ack;
        n_vec++;
        if (ack !== 1'b1 || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL xfer_ack: ack=%0b ram_we=%0b, required ack=1 ram_we=0", ack, ram_we);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        fpga_req = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (ram_we !== 1'b0 || ram_addr !== 12'h0 || ram_wdata !== 32'h0 || cpu_ack !== 1'b0 ||
            fpga_ack !== 1'b0 || cpu_rdata !== 32'h0 || fpga_rdata !== 32'h0 || owner !== 1'b0 || cpu_enable !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: we=%0b addr=%h wdata=%h acks=%0b%0b rdata=%h/%h owner=%0b en=%0b, required all 0, en=1",
                     ram_we, ram_addr, ram_wdata, cpu_ack, fpga_ack, cpu_rdata, fpga_rdata, owner, cpu_enable);
        end
        fpga_lock = 1'b1;
        #1;
        n_vec++;
        if (cpu_enable !== 1'b0) begin
            n_err++;
            $display("FAIL reset_lock_enable: cpu_enable=%0b, required 0", cpu_enable);
        end
        fpga_lock = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    task automatic test_store_load();
        xfer(1'b0, 1'b1, 12'h010, 32'hDEADBEEF);
        xfer(1'b0, 1'b0, 12'h010, 32'h0);
        n_vec++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL load_hold: cpu_rdata=%h, required deadbeef", cpu_rdata);
        end
    endtask

    task automatic test_fpga_access();
        xfer(1'b1, 1'b1, 12'h100, 32'hCAFEF00D);
        xfer(1'b1, 1'b0, 12'h100, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        fpga_req = 1'b1; fpga_we = 1'b1; fpga_addr = 12'h055; fpga_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        n_vec++;
        if (ram_we !== 1'b1 || ram_addr !== 12'h055) begin
            n_err++;
            $display("FAIL midwr_access: ram_we=%0b addr=%h, required 1/055", ram_we, ram_addr);
        end
        #2 nrst = 1'b0;
        #1;
        n_vec++;
        if (ram_we !== 1'b0 || ram_addr !== 12'h0 || ram_wdata !== 32'h0 || fpga_ack !== 1'b0 ||
            owner !== 1'b0 || fpga_rdata !== 32'h0 || cpu_rdata !== 32'h0 || cpu_enable !== 1'b1) begin
            n_err++;
            $display("FAIL midwr_reset: we=%0b addr=%h wdata=%h ack=%0b owner=%0b rdata=%h/%h en=%0b, required zeros, en=1",
                     ram_we, ram_addr, ram_wdata, fpga_ack, owner, fpga_rdata, cpu_rdata, cpu_enable);
        end
        fpga_req = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (fpga_ack !== 1'b0 || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL midwr_after: fpga_ack=%0b ram_we=%0b, required 0/0", fpga_ack, ram_we);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b0, 12'h010, 32'h0);
            push(1'b1, 1'b0, 12'h100, 32'h0);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
        fpga_req = 1'b1; fpga_we = 1'b0; fpga_addr = 12'h100;
        repeat (12) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        fpga_req = 1'b0;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL alt_count: %0d acks outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++)
            push(1'b1, 1'b0, 12'h100, 32'h0);
        fpga_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
        fpga_req = 1'b1; fpga_we = 1'b0; fpga_addr = 12'h100;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (cpu_enable !== 1'b0 || cpu_ack !== 1'b0) begin
                n_err++;
                $display("FAIL lock_stall: cycle %0d cpu_enable=%0b cpu_ack=%0b, required 0/0", i, cpu_enable, cpu_ack);
            end
        end
        fpga_lock = 1'b0;
        push(1'b0, 1'b0, 12'h010, 32'h0);
        #1;
        n_vec++;
        if (cpu_enable !== 1'b1) begin
            n_err++;
            $display("FAIL unlock_enable: cpu_enable=%0b, required 1", cpu_enable);
        end
        @(posedge clk); #1;
        n_vec++;
        if (owner !== 1'b0 || ram_addr !== 12'h010) begin
            n_err++;
            $display("FAIL unlock_grant: owner=%0b addr=%h, required 0/010", owner, ram_addr);
        end
        @(posedge clk); #1;
        n_vec++;
        if (cpu_ack !== 1'b1 || cpu_enable !== 1'b1) begin
            n_err++;
            $display("FAIL unlock_ack: cpu_ack=%0b cpu_enable=%0b, required 1/1", cpu_ack, cpu_enable);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        fpga_req = 1'b0;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL lock_count: %0d acks outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_input_change();
        xfer(1'b0, 1'b1, 12'h020, 32'h11112222);
        xfer(1'b0, 1'b1, 12'h030, 32'h33334444);
        push(1'b0, 1'b0, 12'h020, 32'h0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
        @(posedge clk); #1;
        cpu_addr = 12'h030;
        cpu_we = 1'b1;
        n_vec++;
        if (ram_addr !== 12'h020 || ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL change_access: addr=%h we=%0b, required 020/0", ram_addr, ram_we);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ram_addr !== 12'h020 || cpu_ack !== 1'b1) begin
            n_err++;
            $display("FAIL change_done: addr=%h ack=%0b, required 020/1", ram_addr, cpu_ack);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (ram_we !== 1'b0 || cpu_ack !== 1'b0 || fpga_ack !== 1'b0 || cpu_enable !== 1'b1) begin
                n_err++;
                $display("FAIL idle: cycle %0d we=%0b acks=%0b%0b en=%0b, required 0/00/1",
                         i, ram_we, cpu_ack, fpga_ack, cpu_enable);
            end
        end
    endtask

    initial begin
        nrst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fpga_req = 1'b0; fpga_we = 1'b0; fpga_addr = '0; fpga_wdata = '0; fpga_lock = 1'b0;
        test_reset();
        test_store_load();
        test_fpga_access();
        test_reset_mid_write();
        test_alternate();
        test_lock();
        test_input_change();
        test_idle();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL final_sb: %0d acks outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
